// File: rtl/capture_sequencer_if.sv
`default_nettype none
//============================================================================
// Module      : capture_sequencer_if
// Description : Command/config bus between the PS command path (already in
//               the adc_clk domain) and capture_sequencer.
//               master : command source (drives valid/op/config)
//               slave  : capture_sequencer (drives cmd_ready)
//   cmd_valid        command valid
//   cmd_ready        command ready
//   cmd_op           0=ARM 1=START 2=STOP 3=CLEAR
//   cfg_sample_limit sample limit, 0 = unlimited (latched on ARM)
//   cfg_timeout      capture timeout in cycles, 0 = disabled (latched on ARM)
// Revision    : 1.0 - initial release
//============================================================================
interface capture_sequencer_if #(
  parameter int COUNT_WIDTH = 32
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [1:0]             cmd_op;
  logic [COUNT_WIDTH-1:0] cfg_sample_limit;
  logic [COUNT_WIDTH-1:0] cfg_timeout;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cfg_sample_limit,
    output cfg_timeout,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cfg_sample_limit,
    input  cfg_timeout,
    output cmd_ready
  );
endinterface
`default_nettype wire

// File: rtl/capture_sequencer.sv
`default_nettype none
//============================================================================
// Module      : capture_sequencer
// Description : Sequences one acquisition through the receive chain:
//               IDLE -> CLEARING -> ARMED -> CAPTURE -> DRAIN -> DONE.
//               Pulses adc_reset_state into the discriminator and buffer,
//               gates buffer writes, counts qualified samples and trigger
//               events, and ends capture on limit, buffer full, timeout or
//               software stop.
// Ports       :
//   adc_clk, adc_reset      clock, synchronous active-high reset
//   cmd                     command/config bus (slave modport)
//   adc_valid_in            per-channel sample valid from discriminator
//   adc_timestamp_valid_in  per-channel trigger-event strobe
//   buffer_full             capture buffer has no free space
//   adc_reset_state         state reset to discriminator/buffer
//   capture_enable          buffer write enable gate
//   sw_trigger              one-cycle software trigger
//   buffer_stop             one-cycle end-of-capture strobe
//   done, state             state decodes
//   stop_reason             0 none, 1 limit, 2 full, 3 timeout, 4 sw stop
//   sample_count            valid samples this acquisition (saturating)
//   event_count             trigger events this acquisition (saturating)
// Revision    : 1.0 - initial release
//============================================================================
module capture_sequencer #(
  parameter int CHANNELS     = 8,
  parameter int RESET_CYCLES = 4,
  parameter int DRAIN_CYCLES = 72,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                   adc_clk,
  input  logic                   adc_reset,
  capture_sequencer_if.slave     cmd,
  input  logic [CHANNELS-1:0]    adc_valid_in,
  input  logic [CHANNELS-1:0]    adc_timestamp_valid_in,
  input  logic                   buffer_full,
  output logic                   adc_reset_state,
  output logic                   capture_enable,
  output logic                   sw_trigger,
  output logic                   buffer_stop,
  output logic                   done,
  output logic [2:0]             state,
  output logic [2:0]             stop_reason,
  output logic [COUNT_WIDTH-1:0] sample_count,
  output logic [COUNT_WIDTH-1:0] event_count
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEARING = 3'd1,
    S_ARMED    = 3'd2,
    S_CAPTURE  = 3'd3,
    S_DRAIN    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam logic [1:0] c_OP_ARM   = 2'd0;
  localparam logic [1:0] c_OP_START = 2'd1;
  localparam logic [1:0] c_OP_STOP  = 2'd2;
  localparam logic [1:0] c_OP_CLEAR = 2'd3;

  localparam logic [2:0] c_REASON_NONE    = 3'd0;
  localparam logic [2:0] c_REASON_LIMIT   = 3'd1;
  localparam logic [2:0] c_REASON_FULL    = 3'd2;
  localparam logic [2:0] c_REASON_TIMEOUT = 3'd3;
  localparam logic [2:0] c_REASON_SW      = 3'd4;

  localparam logic [COUNT_WIDTH-1:0] c_CLEAR_LAST = COUNT_WIDTH'(RESET_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] c_DRAIN_LAST = COUNT_WIDTH'(DRAIN_CYCLES - 1);

  function automatic logic [COUNT_WIDTH-1:0] popcount(input logic [CHANNELS-1:0] v);
    logic [COUNT_WIDTH-1:0] n;
    n = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      n = n + COUNT_WIDTH'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] sat_add(input logic [COUNT_WIDTH-1:0] a,
                                                     input logic [COUNT_WIDTH-1:0] b);
    logic [COUNT_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[COUNT_WIDTH] ? '1 : s[COUNT_WIDTH-1:0];
  endfunction

  state_t                 r_state;
  state_t                 w_next;
  logic [2:0]             w_reason_next;

  logic [COUNT_WIDTH-1:0] r_timer;
  logic [COUNT_WIDTH-1:0] r_limit;
  logic [COUNT_WIDTH-1:0] r_timeout;
  logic [COUNT_WIDTH-1:0] r_sample_count;
  logic [COUNT_WIDTH-1:0] r_event_count;
  logic [2:0]             r_stop_reason;
  logic                   r_adc_reset_state;
  logic                   r_capture_enable;
  logic                   r_sw_trigger;
  logic                   r_buffer_stop;

  logic                   w_ready;
  logic                   w_accept;
  logic                   w_op_arm;
  logic                   w_op_start;
  logic                   w_op_stop;
  logic                   w_op_clear;
  logic                   w_counting;
  logic                   w_new_acq;
  logic [COUNT_WIDTH-1:0] w_sample_sum;
  logic [COUNT_WIDTH-1:0] w_event_sum;
  logic                   w_hit_limit;
  logic                   w_hit_timeout;

  // Commands are refused while the reset pulse or the drain wait is running,
  // so an ARM sent during DRAIN waits on the bus until DONE.
  assign w_ready    = !(r_state == S_CLEARING || r_state == S_DRAIN);
  assign w_accept   = cmd.cmd_valid && w_ready;
  assign w_op_arm   = w_accept && (cmd.cmd_op == c_OP_ARM);
  assign w_op_start = w_accept && (cmd.cmd_op == c_OP_START);
  assign w_op_stop  = w_accept && (cmd.cmd_op == c_OP_STOP);
  assign w_op_clear = w_accept && (cmd.cmd_op == c_OP_CLEAR);

  assign w_counting   = (r_state == S_ARMED) || (r_state == S_CAPTURE);
  assign w_new_acq    = (r_state == S_IDLE || r_state == S_DONE) && w_op_arm;
  assign w_sample_sum = sat_add(r_sample_count, popcount(adc_valid_in));
  assign w_event_sum  = sat_add(r_event_count, popcount(adc_timestamp_valid_in));

  // Limit uses the count including this cycle's samples, so capture ends on
  // the cycle that crosses the limit rather than one cycle late.
  assign w_hit_limit   = (r_limit != '0) && (w_sample_sum >= r_limit);
  assign w_hit_timeout = (r_timeout != '0) && (r_timer == r_timeout - COUNT_WIDTH'(1));

  always_ff @(posedge adc_clk) begin
    if (adc_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_reason_next = r_stop_reason;
    case (r_state)
      S_IDLE: begin
        if (w_op_arm) w_next = S_CLEARING;
      end
      S_CLEARING: begin
        if (r_timer == c_CLEAR_LAST) w_next = S_ARMED;
      end
      S_ARMED: begin
        if (w_op_clear) begin
          w_next        = S_IDLE;
          w_reason_next = c_REASON_SW;
        end else if (w_op_stop) begin
          w_next        = S_DRAIN;
          w_reason_next = c_REASON_SW;
        end else if (|adc_timestamp_valid_in) begin
          w_next = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        // Priority: sw stop > buffer full > limit > timeout.
        if (w_op_clear) begin
          w_next        = S_IDLE;
          w_reason_next = c_REASON_SW;
        end else if (w_op_stop) begin
          w_next        = S_DRAIN;
          w_reason_next = c_REASON_SW;
        end else if (buffer_full) begin
          w_next        = S_DRAIN;
          w_reason_next = c_REASON_FULL;
        end else if (w_hit_limit) begin
          w_next        = S_DRAIN;
          w_reason_next = c_REASON_LIMIT;
        end else if (w_hit_timeout) begin
          w_next        = S_DRAIN;
          w_reason_next = c_REASON_TIMEOUT;
        end
      end
      S_DRAIN: begin
        if (r_timer == c_DRAIN_LAST) w_next = S_DONE;
      end
      S_DONE: begin
        if (w_op_arm) begin
          w_next = S_CLEARING;
        end else if (w_op_clear) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge adc_clk) begin
    if (adc_reset) begin
      r_timer           <= '0;
      r_limit           <= '0;
      r_timeout         <= '0;
      r_sample_count    <= '0;
      r_event_count     <= '0;
      r_stop_reason     <= c_REASON_NONE;
      r_adc_reset_state <= 1'b0;
      r_capture_enable  <= 1'b0;
      r_sw_trigger      <= 1'b0;
      r_buffer_stop     <= 1'b0;
    end else begin
      // One timer serves CLEARING, CAPTURE and DRAIN; it restarts at 0 on
      // every state change so each state sees its own cycle index.
      r_timer <= (w_next != r_state) ? '0 : r_timer + COUNT_WIDTH'(1);

      if (w_new_acq) begin
        r_limit        <= cmd.cfg_sample_limit;
        r_timeout      <= cmd.cfg_timeout;
        r_sample_count <= '0;
        r_event_count  <= '0;
        r_stop_reason  <= c_REASON_NONE;
      end else begin
        if (w_counting) begin
          r_sample_count <= w_sample_sum;
          r_event_count  <= w_event_sum;
        end
        r_stop_reason <= w_reason_next;
      end

      // Registered from the next state so each output lines up with the
      // state it belongs to.
      r_adc_reset_state <= (w_next == S_CLEARING);
      r_capture_enable  <= (w_next == S_ARMED) || (w_next == S_CAPTURE);
      r_sw_trigger      <= (r_state == S_ARMED) && w_op_start;
      r_buffer_stop     <= (r_state == S_DRAIN) && (w_next == S_DONE);
    end
  end

  assign cmd.cmd_ready    = w_ready;
  assign done             = (r_state == S_DONE);
  assign state            = r_state;
  assign stop_reason      = r_stop_reason;
  assign sample_count     = r_sample_count;
  assign event_count      = r_event_count;
  assign adc_reset_state  = r_adc_reset_state;
  assign capture_enable   = r_capture_enable;
  assign sw_trigger       = r_sw_trigger;
  assign buffer_stop      = r_buffer_stop;

endmodule
`default_nettype wire

// File: tb/tb_capture_sequencer.sv
`default_nettype none
//============================================================================
// Module      : tb_capture_sequencer
// Description : Self-checking bench for capture_sequencer. Stimulus is
//               applied on the falling edge; a phase-level reference model
//               predicts the registered outputs after the next rising edge
//               and queues them; a monitor pops and compares each cycle.
// Revision    : 1.0 - initial release
//============================================================================
module tb_capture_sequencer;
  localparam int CHANNELS     = 8;
  localparam int RESET_CYCLES = 4;
  localparam int DRAIN_CYCLES = 72;
  localparam int COUNT_WIDTH  = 32;
  localparam longint SAT      = 64'h0000_0000_FFFF_FFFF;

  logic                   adc_clk = 1'b0;
  logic                   adc_reset;
  logic [CHANNELS-1:0]    adc_valid_in;
  logic [CHANNELS-1:0]    adc_timestamp_valid_in;
  logic                   buffer_full;
  logic                   adc_reset_state;
  logic                   capture_enable;
  logic                   sw_trigger;
  logic                   buffer_stop;
  logic                   done;
  logic [2:0]             state;
  logic [2:0]             stop_reason;
  logic [COUNT_WIDTH-1:0] sample_count;
  logic [COUNT_WIDTH-1:0] event_count;

  capture_sequencer_if #(.COUNT_WIDTH(COUNT_WIDTH)) cif ();

  capture_sequencer #(
    .CHANNELS(CHANNELS), .RESET_CYCLES(RESET_CYCLES),
    .DRAIN_CYCLES(DRAIN_CYCLES), .COUNT_WIDTH(COUNT_WIDTH)
  ) dut (
    .adc_clk(adc_clk), .adc_reset(adc_reset), .cmd(cif),
    .adc_valid_in(adc_valid_in), .adc_timestamp_valid_in(adc_timestamp_valid_in),
    .buffer_full(buffer_full), .adc_reset_state(adc_reset_state),
    .capture_enable(capture_enable), .sw_trigger(sw_trigger),
    .buffer_stop(buffer_stop), .done(done), .state(state),
    .stop_reason(stop_reason), .sample_count(sample_count),
    .event_count(event_count)
  );

  always #5 adc_clk = ~adc_clk;

  int total = 0;
  int bad   = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  // Expected registered outputs after one rising edge
  typedef struct {
    int     st;
    bit     rdy, ars, cen, swt, bst, dn;
    int     rsn;
    longint sc, ec;
  } exp_t;
  exp_t q[$];

  // Reference model: acquisition phase plus countdowns in plain integers
  int     m_phase = 0;  // 0 idle,1 clearing,2 armed,3 capture,4 drain,5 done
  int     m_clr_left, m_drn_left;
  longint m_cap, m_limit, m_tmo, m_sc, m_ec;
  int     m_rsn;
  bit     m_sw, m_bst, m_acc;

  // Stimulus variables applied on each falling edge
  bit          rst_d, cv_d, full_d, loop_en;
  int          op_d;
  longint      lim_d, tmo_d;
  logic [7:0]  vin_d, ts_d;
  bit          stim_done = 0;

  task automatic to_drain(input int reason);
    m_phase = 4; m_drn_left = DRAIN_CYCLES; m_rsn = reason;
  endtask

  task automatic model_step();
    int nv, ne;
    bit rdy, arm, start, stop, clr;
    exp_t e;
    nv = $countones(adc_valid_in);
    ne = $countones(adc_timestamp_valid_in);
    m_acc = 0; m_sw = 0; m_bst = 0;
    if (adc_reset) begin
      m_phase = 0; m_sc = 0; m_ec = 0; m_rsn = 0; m_limit = 0; m_tmo = 0;
    end else begin
      rdy   = !(m_phase == 1 || m_phase == 4);
      m_acc = cif.cmd_valid && rdy;
      arm   = m_acc && cif.cmd_op == 2'd0;
      start = m_acc && cif.cmd_op == 2'd1;
      stop  = m_acc && cif.cmd_op == 2'd2;
      clr   = m_acc && cif.cmd_op == 2'd3;
      if (m_phase == 2 || m_phase == 3) begin
        m_sc = (m_sc + nv > SAT) ? SAT : m_sc + nv;
        m_ec = (m_ec + ne > SAT) ? SAT : m_ec + ne;
      end
      case (m_phase)
        0, 5: begin
          if (arm) begin
            m_limit = longint'(cif.cfg_sample_limit); m_tmo = longint'(cif.cfg_timeout);
            m_sc = 0; m_ec = 0; m_rsn = 0; m_clr_left = RESET_CYCLES; m_phase = 1;
          end else if (clr) begin
            m_phase = 0;
          end
        end
        1: begin
          m_clr_left--;
          if (m_clr_left == 0) m_phase = 2;
        end
        2: begin
          m_sw = start;
          if (clr) begin m_phase = 0; m_rsn = 4; end
          else if (stop) to_drain(4);
          else if (ne > 0) begin m_phase = 3; m_cap = 0; end
        end
        3: begin
          m_cap++;
          if (clr) begin m_phase = 0; m_rsn = 4; end
          else if (stop) to_drain(4);
          else if (buffer_full) to_drain(2);
          else if (m_limit != 0 && m_sc >= m_limit) to_drain(1);
          else if (m_tmo != 0 && m_cap == m_tmo) to_drain(3);
        end
        4: begin
          m_drn_left--;
          if (m_drn_left == 0) begin m_phase = 5; m_bst = 1; end
        end
        default: m_phase = 0;
      endcase
    end
    e.st  = m_phase;
    e.rdy = !(m_phase == 1 || m_phase == 4);
    e.ars = (m_phase == 1);
    e.cen = (m_phase == 2 || m_phase == 3);
    e.swt = m_sw;
    e.bst = m_bst;
    e.dn  = (m_phase == 5);
    e.rsn = m_rsn;
    e.sc  = m_sc;
    e.ec  = m_ec;
    q.push_back(e);
  endtask

  task automatic apply();
    logic [7:0] ts;
    ts = ts_d;
    if (loop_en && sw_trigger === 1'b1) ts[3] = 1'b1;
    adc_reset              = rst_d;
    cif.cmd_valid          = cv_d;
    cif.cmd_op             = 2'(op_d);
    cif.cfg_sample_limit   = 32'(lim_d);
    cif.cfg_timeout        = 32'(tmo_d);
    adc_valid_in           = vin_d;
    adc_timestamp_valid_in = ts;
    buffer_full            = full_d;
    model_step();
  endtask

  task automatic tick();
    @(negedge adc_clk);
    apply();
  endtask

  // Wait for the next rising edge so the DUT reflects the last tick
  task automatic settle();
    @(posedge adc_clk);
    #2;
  endtask

  task automatic wait_phase(input int p, input int budget, input string name);
    int n;
    n = 0;
    while (m_phase != p && n < budget) begin tick(); n++; end
    if (m_phase != p) cmp({name, "_timeout"}, 64'(m_phase), 64'(p));
  endtask

  task automatic send(input int op, input string name);
    int n;
    cv_d = 1; op_d = op; n = 0;
    do begin tick(); n++; end while (!m_acc && n < 300);
    if (!m_acc) cmp({name, "_not_accepted"}, 0, 1);
    cv_d = 0;
  endtask

  // Monitor: one expected record per rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge adc_clk);
      #1;
      if (!stim_done) begin
        if (q.size() == 0) begin
          cmp("scoreboard_empty", 0, 1);
        end else begin
          e = q.pop_front();
          cmp("state",           state,           e.st);
          cmp("cmd_ready",       cif.cmd_ready,   e.rdy);
          cmp("adc_reset_state", adc_reset_state, e.ars);
          cmp("capture_enable",  capture_enable,  e.cen);
          cmp("sw_trigger",      sw_trigger,      e.swt);
          cmp("buffer_stop",     buffer_stop,     e.bst);
          cmp("done",            done,            e.dn);
          cmp("stop_reason",     stop_reason,     e.rsn);
          cmp("sample_count",    sample_count,    e.sc);
          cmp("event_count",     event_count,     e.ec);
        end
      end
    end
  end

  initial begin
    rst_d = 1; cv_d = 0; op_d = 0; lim_d = 0; tmo_d = 0;
    vin_d = 0; ts_d = 0; full_d = 0; loop_en = 0;
    apply();
    repeat (3) tick();
    rst_d = 0;
    tick();
    settle();
    cmp("rst_state", state, 0);
    cmp("rst_cmd_ready", cif.cmd_ready, 1);
    cmp("rst_capture_enable", capture_enable, 0);
    cmp("rst_sample_count", sample_count, 0);

    // Limit 100 with all channels valid: ends on the 13th full cycle
    lim_d = 100; tmo_d = 0;
    send(0, "arm1");
    wait_phase(2, 20, "armed1");
    ts_d = 8'h01; tick(); ts_d = 8'h00;
    vin_d = 8'hFF;
    wait_phase(4, 50, "drain1");
    vin_d = 8'h00;
    wait_phase(5, 200, "done1");
    settle();
    cmp("lim_sample_count", sample_count, 104);
    cmp("lim_stop_reason", stop_reason, 1);
    cmp("lim_event_count", event_count, 1);
    cmp("lim_done", done, 1);
    cmp("lim_buffer_stop", buffer_stop, 1);

    // Timeout 10, no data
    lim_d = 0; tmo_d = 10;
    send(0, "arm2");
    wait_phase(2, 20, "armed2");
    repeat (3) tick();
    ts_d = 8'h04; tick(); ts_d = 8'h00;
    wait_phase(5, 200, "done2");
    settle();
    cmp("tmo_stop_reason", stop_reason, 3);
    cmp("tmo_sample_count", sample_count, 0);

    // Buffer full on the same cycle the limit is crossed
    lim_d = 50; tmo_d = 0;
    send(0, "arm3");
    wait_phase(2, 20, "armed3");
    ts_d = 8'h01; tick(); ts_d = 8'h00;
    vin_d = 8'hFF;
    for (int i = 0; i < 50 && m_phase == 3; i++) begin
      full_d = (m_sc + 8 >= 50);
      tick();
    end
    full_d = 0; vin_d = 8'h00;
    wait_phase(5, 200, "done3");
    settle();
    cmp("full_stop_reason", stop_reason, 2);
    cmp("full_sample_count", sample_count, 56);

    // STOP and buffer full together
    lim_d = 0;
    send(0, "arm4");
    wait_phase(2, 20, "armed4");
    ts_d = 8'h01; tick(); ts_d = 8'h00;
    repeat (3) tick();
    full_d = 1;
    send(2, "stop4");
    full_d = 0;
    wait_phase(5, 200, "done4");
    settle();
    cmp("stopfull_stop_reason", stop_reason, 4);

    // START looped back to ch3 timestamp valid
    loop_en = 1;
    send(0, "arm5");
    wait_phase(2, 20, "armed5");
    send(1, "start5");
    tick();
    settle();
    cmp("loop_event_count", event_count, 1);
    cmp("loop_state", state, 3);
    send(2, "stop5");
    cv_d = 1; op_d = 0;
    tick();
    settle();
    cmp("drain_cmd_ready", cif.cmd_ready, 0);
    cmp("drain_state", state, 4);
    for (int i = 0; i < 200 && !m_acc; i++) tick();
    cv_d = 0;
    settle();
    cmp("arm_after_done_state", state, 1);
    loop_en = 0;
    wait_phase(2, 20, "armed6");

    // CLEAR mid-capture at 37 samples
    ts_d = 8'h01; tick(); ts_d = 8'h00;
    vin_d = 8'hFF; repeat (4) tick();
    vin_d = 8'h1F; tick();
    vin_d = 8'h00;
    send(3, "clear6");
    settle();
    cmp("clr_state", state, 0);
    cmp("clr_sample_count", sample_count, 37);
    cmp("clr_stop_reason", stop_reason, 4);
    cmp("clr_buffer_stop", buffer_stop, 0);

    // Reset mid-capture
    send(0, "arm7");
    wait_phase(2, 20, "armed7");
    ts_d = 8'h02; tick(); ts_d = 8'h00;
    vin_d = 8'h5A; repeat (3) tick();
    rst_d = 1; tick(); rst_d = 0;
    settle();
    cmp("mrst_state", state, 0);
    cmp("mrst_sample_count", sample_count, 0);
    cmp("mrst_event_count", event_count, 0);
    cmp("mrst_capture_enable", capture_enable, 0);
    cmp("mrst_cmd_ready", cif.cmd_ready, 1);

    // Randomized traffic, sw_trigger looped back
    loop_en = 1;
    for (int c = 0; c < 6000; c++) begin
      int r;
      rst_d = ($urandom_range(0, 599) == 0);
      if (!cv_d) begin
        r = $urandom_range(0, 199);
        case (m_phase)
          0, 5: if (r < 35) begin cv_d = 1; op_d = (r < 5) ? 3 : 0; end
          2:    if (r < 12) begin cv_d = 1; op_d = (r < 8) ? 1 : (r < 10) ? 2 : 3; end
          3:    if (r < 3)  begin cv_d = 1; op_d = (r == 0) ? 2 : (r == 1) ? 3 : 1; end
          4:    if (r < 4)  begin cv_d = 1; op_d = 0; end
          default: ;
        endcase
        lim_d = ($urandom_range(0, 2) == 0) ? 0 : longint'($urandom_range(20, 200));
        tmo_d = ($urandom_range(0, 2) == 0) ? 0 : longint'($urandom_range(1, 30));
      end
      vin_d = 8'($urandom);
      ts_d  = 8'h00;
      if (m_phase == 2 && $urandom_range(0, 11) == 0) ts_d = 8'(1 << $urandom_range(0, 7));
      if (m_phase == 3 && $urandom_range(0, 3) == 0) ts_d = 8'($urandom & $urandom);
      full_d = ($urandom_range(0, 79) == 0);
      tick();
      if (m_acc || rst_d) cv_d = 0;
    end

    @(posedge adc_clk);
    #2;
    stim_done = 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
- Single-clock (adc_clk) controller that sequences one acquisition through the receive chain: clear, arm, capture, drain, done.
- Pulses adc_reset_state into sample_discriminator and the capture buffer.
- Gates buffer writes, counts discriminator-qualified samples and trigger events, and terminates capture on sample limit, buffer full, timeout or software stop.
- Sits between the PS command path (already CDC'd into adc_clk) and the discriminator/buffer pair.

Parameters:
- CHANNELS, 8, number of receive channels (matches rx_pkg::CHANNELS).
- RESET_CYCLES, 4, cycles adc_reset_state is held in CLEARING (>=1).
- DRAIN_CYCLES, 72, cycles waited after capture end before buffer_stop; covers max discriminator delay plus latency (>=1).
- COUNT_WIDTH, 32, width of sample/event counters, sample limit and timeout.

Ports:
- adc_clk  in  1  clock
- adc_reset  in  1  synchronous active-high reset
- cmd_valid  in  1  command handshake valid
- cmd_ready  out  1  command handshake ready
- cmd_op  in  2  0=ARM, 1=START (software trigger), 2=STOP, 3=CLEAR
- cfg_sample_limit  in  COUNT_WIDTH  total valid samples to capture; 0 = unlimited; latched on ARM
- cfg_timeout  in  COUNT_WIDTH  max CAPTURE cycles; 0 = disabled; latched on ARM
- adc_valid_in  in  CHANNELS  per-channel data valid from discriminator output
- adc_timestamp_valid_in  in  CHANNELS  per-channel trigger-event strobe from discriminator
- buffer_full  in  1  capture buffer has no free space
- adc_reset_state  out  1  state reset to discriminator/buffer
- capture_enable  out  1  buffer write enable gate
- sw_trigger  out  1  single-cycle software trigger (routed to a digital trigger input)
- buffer_stop  out  1  single-cycle end-of-capture strobe to buffer
- done  out  1  high while in DONE
- state  out  3  current state encoding
- stop_reason  out  3  0 none, 1 limit, 2 full, 3 timeout, 4 sw stop
- sample_count  out  COUNT_WIDTH  valid samples counted this acquisition
- event_count  out  COUNT_WIDTH  trigger events counted this acquisition

Behaviour:
- Reset: state=IDLE(0); all outputs 0 except cmd_ready=1; counters, latched config and stop_reason cleared.
- Handshake: command accepted on cmd_valid & cmd_ready. cmd_ready=0 in CLEARING and DRAIN, 1 otherwise. A command that is accepted but not listed for the current state is ignored (dropped).
- IDLE(0):
  - ARM -> CLEARING.
  - Latch cfg_sample_limit and cfg_timeout.
  - Clear counters, stop_reason and timer.
- CLEARING(1):
  - adc_reset_state=1 for exactly RESET_CYCLES cycles, then -> ARMED.
  - Counters do not count.
- ARMED(2):
  - capture_enable=1.
  - START -> sw_trigger=1 for one cycle, registered, on the cycle after acceptance.
  - Any bit of adc_timestamp_valid_in -> CAPTURE next cycle; a trigger on that same cycle is counted in event_count.
  - START does not change state; the resulting discriminator event does.
  - STOP -> DRAIN with stop_reason=4.
- CAPTURE(3):
  - capture_enable=1.
  - sample_count += popcount(adc_valid_in) and event_count += popcount(adc_timestamp_valid_in) every cycle in ARMED and CAPTURE. Both counters saturate at all-ones.
  - Timer starts at 0 on the first CAPTURE cycle and increments each cycle.
  - End conditions are evaluated each cycle using this cycle's updated count:
    - sw STOP accepted;
    - buffer_full;
    - limit != 0 and (sample_count + popcount) >= limit;
    - timeout != 0 and timer == timeout-1.
  - Any end condition -> DRAIN next cycle. Samples on the terminating cycle are counted.
  - Priority for stop_reason when simultaneous: sw stop > full > limit > timeout.
  - With timeout=T, CAPTURE lasts exactly T cycles.
- DRAIN(4):
  - capture_enable=0; counters frozen.
  - After DRAIN_CYCLES cycles, buffer_stop=1 for one cycle coincident with -> DONE.
- DONE(5):
  - done=1; counters and stop_reason hold.
  - ARM -> CLEARING (new acquisition, re-latch config).
  - CLEAR -> IDLE.
- CLEAR in IDLE/ARMED/CAPTURE/DONE:
  - -> IDLE next cycle; capture_enable drops next cycle.
  - No buffer_stop issued; counters hold values.
  - stop_reason=4 if leaving ARMED/CAPTURE.
- adc_reset asserted mid-operation: immediate return to reset values on the next edge; no buffer_stop pulse.
- Outputs are all registered except cmd_ready, done and state, which decode the state register.

Test Plan:
- Reset, ARM with limit=100, timeout=0, RESET_CYCLES=4 -> adc_reset_state high exactly 4 cycles, then state=2 and capture_enable=1.
- ARMED, single trigger on ch0, then adc_valid_in=8'hFF every cycle -> CAPTURE; stop on the cycle count reaches >=100 (13th full cycle, sample_count=104); stop_reason=1; buffer_stop exactly DRAIN_CYCLES cycles after capture_enable falls; done=1.
- timeout=10, no valid data, trigger at cycle t -> capture_enable high for 10 CAPTURE cycles; stop_reason=3; sample_count=0.
- buffer_full and limit reached on the same cycle -> stop_reason=2; STOP plus buffer_full on the same cycle -> stop_reason=4.
- START in ARMED -> sw_trigger one-cycle pulse; loop sw_trigger back to ch3 timestamp valid -> event_count=1, state=3. Send ARM while in DRAIN -> cmd_ready=0 and the command is not consumed until DONE.
- CLEAR mid-CAPTURE with sample_count=37 -> IDLE next cycle; no buffer_stop; sample_count holds 37. adc_reset mid-CAPTURE -> all outputs return to reset values.
